// File: rtl/debug_pkg.sv
// Shared definitions for the debug trace capture path: word width and FSM encoding.
package debug_pkg;
    localparam int DEBUG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;
endpackage

// File: rtl/debug_trace_ram.sv
// DEPTH x DATA_W trace storage: synchronous write, asynchronous read, no reset.
module debug_trace_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/debug_trace_buffer.sv
// Arm/trigger trace capture of one debug word per timestep, then valid/ready playout.
module debug_trace_buffer
    import debug_pkg::*;
#(
    parameter int DATA_W = DEBUG_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_ext,
    input  logic              trig_on_nonzero,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] debug_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [1:0]        state_o,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] ram_rdata;
    logic              trig, wr_en, wr_end, rd_fire;

    assign trig    = sample_en & (trig_ext | (trig_on_nonzero & (|debug_data)));
    // abort outranks any write in the same cycle
    assign wr_en   = !abort && ((state == ST_ARMED && trig) || (state == ST_CAPTURE && sample_en));
    assign wr_end  = wr_en && (wr_ptr == LAST);
    assign rd_fire = rd_valid & rd_ready;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (arm) state_nxt = ST_ARMED;
                ST_ARMED:   if (wr_en) state_nxt = wr_end ? ST_READOUT : ST_CAPTURE;
                ST_CAPTURE: if (wr_end) state_nxt = ST_READOUT;
                ST_READOUT: if (rd_fire && rd_last) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en)   wr_ptr <= wr_end  ? '0 : wr_ptr + ADDR_W'(1);
                if (rd_fire) rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_W'(1);
            end
        end
    end

    debug_trace_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (debug_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign rd_valid = (state == ST_READOUT);
    assign rd_data  = rd_valid ? ram_rdata : '0;
    assign rd_last  = rd_valid && (rd_ptr == LAST);
    assign state_o  = state;
    assign busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_debug_trace_buffer.sv
// Scoreboard bench for debug_trace_buffer at DEPTH 16, 1 and 4.
module tb_debug_trace_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, abort, trig_ext, trig_on_nonzero, sample_en;
    logic [7:0] debug_data;
    logic       arm, arm1, arm4, rd_ready, rd_ready1, rd_ready4;

    logic       rd_valid, rd_last, busy;
    logic [7:0] rd_data;
    logic [1:0] state_o;
    logic       rd_valid1, rd_last1, busy1;
    logic [7:0] rd_data1;
    logic [1:0] state1;
    logic       rd_valid4, rd_last4, busy4;
    logic [7:0] rd_data4;
    logic [1:0] state4;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         m_armed = 0;
    bit         m_cap   = 0;
    int         m_cnt   = 0;

    debug_trace_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_ext(trig_ext),
        .trig_on_nonzero(trig_on_nonzero), .sample_en(sample_en), .debug_data(debug_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state_o(state_o), .busy(busy)
    );

    debug_trace_buffer #(.DEPTH(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .arm(arm1), .abort(abort), .trig_ext(trig_ext),
        .trig_on_nonzero(trig_on_nonzero), .sample_en(sample_en), .debug_data(debug_data),
        .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1), .rd_last(rd_last1),
        .state_o(state1), .busy(busy1)
    );

    debug_trace_buffer #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst), .arm(arm4), .abort(abort), .trig_ext(trig_ext),
        .trig_on_nonzero(trig_on_nonzero), .sample_en(sample_en), .debug_data(debug_data),
        .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_data(rd_data4), .rd_last(rd_last4),
        .state_o(state4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One timestep strobe plus a gap cycle; the reference model decides what gets captured.
    task automatic sample(input logic [7:0] d, input logic te);
        if (m_armed && (te || (trig_on_nonzero && d != 8'd0))) begin
            m_armed = 0;
            m_cap   = 1;
            m_cnt   = 0;
        end
        if (m_cap) begin
            exp_q.push_back(d);
            m_cnt++;
            if (m_cnt == 16) m_cap = 0;
        end
        sample_en = 1; debug_data = d; trig_ext = te;
        tick();
        sample_en = 0; debug_data = 8'd0; trig_ext = 0;
        tick();
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
        arm = 0;
        m_armed = 1;
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL arm_state got=%0d exp=1", state_o);
        end
    endtask

    task automatic capture16(input logic [7:0] base);
        for (int i = 0; i < 16; i++) sample(base + 8'(i), i == 0);
        checks++;
        if (state_o !== 2'd3) begin
            errors++; $display("FAIL capture_done_state got=%0d exp=3", state_o);
        end
    endtask

    // Pops n words; bp selects ready pattern 1,0,0,1,0,0...
    task automatic drain(input int n, input bit bp, input bit expect_idle);
        int got = 0;
        int cyc = 0;
        logic [7:0] held = 8'd0;
        bit hold_chk = 0;
        logic [7:0] e;
        while (got < n && cyc < 200) begin
            rd_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (hold_chk) begin
                checks++;
                if (rd_data !== held) begin
                    errors++; $display("FAIL hold_stable got=%02h exp=%02h", rd_data, held);
                end
            end
            hold_chk = 0;
            checks++;
            if (rd_valid !== 1'b1) begin
                errors++; $display("FAIL rd_valid got=%b exp=1 word=%0d", rd_valid, got);
                break;
            end
            if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL scoreboard_empty got=word exp=none");
                    break;
                end
                e = exp_q.pop_front();
                checks++;
                if (rd_data !== e) begin
                    errors++; $display("FAIL rd_data got=%02h exp=%02h word=%0d", rd_data, e, got);
                end
                checks++;
                if (rd_last !== (expect_idle && exp_q.size() == 0)) begin
                    errors++; $display("FAIL rd_last got=%b exp=%b word=%0d", rd_last,
                                       (expect_idle && exp_q.size() == 0), got);
                end
                got++;
            end else begin
                held = rd_data;
                hold_chk = 1;
            end
            tick();
            cyc++;
        end
        rd_ready = 0;
        checks++;
        if (got != n) begin
            errors++; $display("FAIL drain_count got=%0d exp=%0d", got, n);
        end
        if (expect_idle) begin
            checks++;
            if (state_o !== 2'd0 || rd_valid !== 1'b0) begin
                errors++; $display("FAIL after_drain state=%0d valid=%b exp=0/0", state_o, rd_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (state_o !== 2'd0 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'd0 ||
                rd_last !== 1'b0) begin
                errors++; $display("FAIL reset_idle st=%0d busy=%b v=%b d=%02h l=%b exp=all 0",
                                   state_o, busy, rd_valid, rd_data, rd_last);
            end
        end
        checks++;
        if (state1 !== 2'd0 || state4 !== 2'd0) begin
            errors++; $display("FAIL reset_other st1=%0d st4=%0d exp=0", state1, state4);
        end
    endtask

    task automatic test_nonzero();
        trig_on_nonzero = 1;
        do_arm();
        sample(8'd0, 0);
        sample(8'd0, 0);
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL zero_no_trig got=%0d exp=1", state_o);
        end
        for (int v = 5; v <= 20; v++) sample(8'(v), 0);
        trig_on_nonzero = 0;
        checks++;
        if (state_o !== 2'd3) begin
            errors++; $display("FAIL nz_readout got=%0d exp=3", state_o);
        end
        drain(16, 0, 1);
    endtask

    task automatic test_back_to_back();
        do_arm();
        capture16(8'd100);
        drain(16, 1, 1);
    endtask

    task automatic test_abort();
        do_arm();
        for (int i = 0; i < 7; i++) sample(8'd30 + 8'(i), i == 0);
        abort = 1;
        tick();
        abort = 0;
        exp_q.delete(); m_cap = 0; m_armed = 0;
        checks++;
        if (state_o !== 2'd0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL abort_capture st=%0d busy=%b v=%b exp=0/0/0", state_o, busy, rd_valid);
        end
        do_arm();
        capture16(8'd50);
        drain(3, 0, 0);
        abort = 1;
        tick();
        abort = 0;
        exp_q.delete();
        checks++;
        if (state_o !== 2'd0 || rd_valid !== 1'b0 || rd_data !== 8'd0) begin
            errors++; $display("FAIL abort_readout st=%0d v=%b d=%02h exp=0/0/00", state_o, rd_valid, rd_data);
        end
        do_arm();
        capture16(8'd70);
        drain(16, 0, 1);
    endtask

    task automatic test_outside();
        for (int i = 0; i < 3; i++) sample(8'hEE, 1);
        checks++;
        if (state_o !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_events st=%0d busy=%b exp=0/0", state_o, busy);
        end
        do_arm();
        capture16(8'd140);
        arm = 1;
        tick();
        arm = 0;
        checks++;
        if (state_o !== 2'd3) begin
            errors++; $display("FAIL arm_in_readout got=%0d exp=3", state_o);
        end
        for (int i = 0; i < 4; i++) sample(8'hFF, 1);
        checks++;
        if (state_o !== 2'd3) begin
            errors++; $display("FAIL sample_in_readout got=%0d exp=3", state_o);
        end
        drain(16, 0, 1);
    endtask

    task automatic test_depth();
        logic [7:0] q4[$];
        logic [7:0] e;
        arm1 = 1; tick(); arm1 = 0;
        checks++;
        if (state1 !== 2'd1) begin
            errors++; $display("FAIL d1_armed got=%0d exp=1", state1);
        end
        sample_en = 1; trig_ext = 1; debug_data = 8'hA5;
        tick();
        sample_en = 0; trig_ext = 0; debug_data = 8'd0;
        checks++;
        if (state1 !== 2'd3 || rd_valid1 !== 1'b1 || rd_data1 !== 8'hA5 || rd_last1 !== 1'b1) begin
            errors++; $display("FAIL d1_word st=%0d v=%b d=%02h l=%b exp=3/1/a5/1",
                               state1, rd_valid1, rd_data1, rd_last1);
        end
        rd_ready1 = 1; tick(); rd_ready1 = 0;
        checks++;
        if (state1 !== 2'd0 || rd_valid1 !== 1'b0) begin
            errors++; $display("FAIL d1_done st=%0d v=%b exp=0/0", state1, rd_valid1);
        end

        arm4 = 1; tick(); arm4 = 0;
        for (int i = 0; i < 4; i++) begin
            q4.push_back(8'd60 + 8'(i));
            sample(8'd60 + 8'(i), i == 0);
        end
        checks++;
        if (state4 !== 2'd3) begin
            errors++; $display("FAIL d4_readout got=%0d exp=3", state4);
        end
        rd_ready4 = 1;
        for (int i = 0; i < 4; i++) begin
            e = q4.pop_front();
            checks++;
            if (rd_valid4 !== 1'b1 || rd_data4 !== e || rd_last4 !== (i == 3)) begin
                errors++; $display("FAIL d4_word%0d v=%b d=%02h l=%b exp=1/%02h/%b",
                                   i, rd_valid4, rd_data4, rd_last4, e, (i == 3));
            end
            tick();
        end
        rd_ready4 = 0;
        checks++;
        if (state4 !== 2'd0) begin
            errors++; $display("FAIL d4_done got=%0d exp=0", state4);
        end
    endtask

    initial begin
        rst = 1; abort = 0; trig_ext = 0; trig_on_nonzero = 0; sample_en = 0;
        debug_data = 8'd0; arm = 0; arm1 = 0; arm4 = 0;
        rd_ready = 0; rd_ready1 = 0; rd_ready4 = 0;
        test_reset();
        test_nonzero();
        test_back_to_back();
        test_abort();
        test_outside();
        test_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
